mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EX/MEM latch and the MEM/WB latch.
- Issues data-memory read/write requests to the dcache and holds them until dhit.
- Stalls upstream stages while the access is outstanding.
- Presents load data and pass-through writeback fields to the MEM/WB latch with an enable.

Parameters:
MAX_WAIT, 64, cycles in ACCESS without dhit before the access is aborted and err set (min 2)
ABORT_DATA, 32'hBAD1BAD1, load value returned on abort

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
valid_in  input  1  EX/MEM holds a valid instruction
memctrl_in  input  2  [1]=load, [0]=store
aluout_in  input  32  ALU result / effective address
storedata_in  input  32  store data
npc_in  input  32  next PC (JAL link)
imm_in  input  16  immediate (LUI)
dest_in  input  5  destination register
WBctrl_in  input  4  writeback control
ihit  input  1  instruction fetch hit (pipeline advance)
dhit  input  1  dcache completes current request
dmemload  input  32  dcache read data
dmemREN  output  1  dcache read request
dmemWEN  output  1  dcache write request
dmemaddr  output  32  dcache address
dmemstore  output  32  dcache write data
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
memwb_en  output  1  MEM/WB latch enable
dmemload_out  output  32  load data to MEM/WB
aluout_out  output  32  to MEM/WB
npc_out  output  32  to MEM/WB
imm_out  output  16  to MEM/WB
dest_out  output  5  to MEM/WB
WBctrl_out  output  4  to MEM/WB
err  output  1  sticky abort flag

Behaviour:
- memop = valid_in & (memctrl_in != 0). If both bits are set, the access is a store; the load is ignored.
- FSM states: IDLE, ACCESS, DONE. All registers are reset asynchronously.
- On RST: state IDLE; dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0; load_q=0; wait counter=0; err=0. Reset mid-ACCESS drops the request immediately.
- IDLE:
  - dmemREN/WEN=0. stall=memop (combinational).
  - On memop at the clock edge, register REN/WEN, dmemaddr={aluout_in[31:2],2'b00} and dmemstore=storedata_in, clear the counter, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Registered requests are driven; stall=1.
  - On dhit: load_q<=dmemload (load) or keep the previous value (store); clear requests; go to DONE.
  - Without dhit: counter+1. When counter==MAX_WAIT-1 and no dhit, load_q<=ABORT_DATA, err<=1, clear requests, go to DONE.
  - dhit takes priority over timeout on the same cycle.
- DONE:
  - stall=0; requests=0.
  - On ihit, go to IDLE. The MEM/WB latch captures on this same edge, and EX/MEM advances.
  - Without ihit, stay in DONE holding load_q.
- A memory op therefore takes at least 3 cycles: IDLE detect, ACCESS (≥1), DONE.
- memwb_en = ihit & ~stall.
- Writeback fields:
  - aluout_out/npc_out/imm_out/dest_out/WBctrl_out pass through combinationally. The EX/MEM latch is frozen by stall, so they stay stable.
  - When valid_in=0, WBctrl_out=0 (bubble).
- dmemload_out = load_q in DONE; otherwise dmemload (don't-care to WB when not a load).
- err remains 1 until RST.
- dmemaddr/dmemstore hold their last values outside ACCESS.

Test Plan:
- Reset during ACCESS (RST pulse between clock edges) -> dmemREN drops to 0 before the next edge; state IDLE; err=0; stall follows memop.
- Load, aluout_in=0x0000_0103, dhit on the 2nd ACCESS cycle with dmemload=0xDEADBEEF -> dmemaddr=0x0000_0100; REN high for 2 cycles; stall high for 3 cycles; dmemload_out=0xDEADBEEF in DONE; memwb_en=1 on the ihit in DONE.
- Store, storedata_in=0x12345678, addr 0x200, dhit on the 1st ACCESS cycle -> WEN high for 1 cycle; dmemstore=0x12345678; REN=0 throughout; DONE on the next cycle.
- memctrl_in=2'b11 -> only dmemWEN asserts.
- Non-memory op (memctrl_in=0, valid_in=1) with ihit=1 -> stall=0, memwb_en=1, no requests, aluout_out=aluout_in; with valid_in=0 -> WBctrl_out=0.
- MAX_WAIT=4, no dhit -> REN high for 4 cycles; then err=1 and dmemload_out=0xBAD1BAD1 in DONE; DONE held while ihit=0, IDLE after ihit; err stays 1 across the following load.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage pipeline, between EX/MEM and MEM/WB.
//   Issues one dcache read or write per memory op and holds it until dhit.
//   Stalls the upstream stages while the access is outstanding.
//   Aborts after MAX_WAIT cycles without dhit, returning ABORT_DATA and setting err.
// Ports:
//   CLK, RST                      clock (rising edge), async active-high reset
//   valid_in, memctrl_in          EX/MEM instruction valid, {load, store}
//   aluout_in, storedata_in       effective address / ALU result, store data
//   npc_in, imm_in, dest_in,      writeback fields from EX/MEM
//   WBctrl_in
//   ihit, dhit, dmemload          fetch hit, dcache done, dcache read data
//   dmemREN, dmemWEN, dmemaddr,   registered dcache request
//   dmemstore
//   stall, memwb_en               pipeline freeze, MEM/WB latch enable
//   dmemload_out, aluout_out,     MEM/WB payload
//   npc_out, imm_out, dest_out,
//   WBctrl_out
//   err                           sticky abort flag
module mem_stage #(
    parameter int unsigned MAX_WAIT   = 64,
    parameter logic [31:0] ABORT_DATA = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    input  logic [1:0]  memctrl_in,
    input  logic [31:0] aluout_in,
    input  logic [31:0] storedata_in,
    input  logic [31:0] npc_in,
    input  logic [15:0] imm_in,
    input  logic [4:0]  dest_in,
    input  logic [3:0]  WBctrl_in,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        stall,
    output logic        memwb_en,
    output logic [31:0] dmemload_out,
    output logic [31:0] aluout_out,
    output logic [31:0] npc_out,
    output logic [15:0] imm_out,
    output logic [4:0]  dest_out,
    output logic [3:0]  WBctrl_out,
    output logic        err
);

    localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       load_q;
    logic              memop;
    logic              is_store;
    logic              is_load;

    // Store wins when both control bits are set.
    assign memop    = valid_in & (memctrl_in != 2'b00);
    assign is_store = memctrl_in[0];
    assign is_load  = memctrl_in[1] & ~memctrl_in[0];

    // Access sequencer: request registers, wait counter, load capture, abort.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            dmemREN   <= 1'b0;
            dmemWEN   <= 1'b0;
            dmemaddr  <= 32'h0;
            dmemstore <= 32'h0;
            load_q    <= 32'h0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        dmemREN   <= is_load;
                        dmemWEN   <= is_store;
                        dmemaddr  <= {aluout_in[31:2], 2'b00};
                        dmemstore <= storedata_in;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // dhit beats timeout on the same cycle.
                    if (dhit) begin
                        if (dmemREN) begin
                            load_q <= dmemload;
                        end
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        load_q  <= ABORT_DATA;
                        err     <= 1'b1;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // MEM/WB captures and EX/MEM advances on this same edge.
                    if (ihit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dmemREN <= 1'b0;
                    dmemWEN <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline freeze: detect cycle in IDLE plus every ACCESS cycle.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = memop;
            ACCESS:  stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    assign memwb_en     = ihit & ~stall;
    assign dmemload_out = (state == DONE) ? load_q : dmemload;

    // EX/MEM is frozen while stalled, so pass-through fields stay stable.
    assign aluout_out = aluout_in;
    assign npc_out    = npc_in;
    assign imm_out    = imm_in;
    assign dest_out   = dest_in;
    assign WBctrl_out = valid_in ? WBctrl_in : 4'h0;

endmodule
